multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
// - Main control FSM for the multicycle MIPS datapath: fetch, decode, execute, memory and writeback, one state per cycle.
// - Drives all datapath enables/muxes; produces alu_operation and feeds it with funct into an aluDecoder to emit alu_control.
// - Stalls on a variable-latency memory (mem_ready); flags illegal opcodes and memory timeouts.
// PARAMETERS
// - MEM_TIMEOUT  15  max wait cycles in a memory state before bus_err; 0 disables timeout
// - CNT_W        4   width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
// - clk            in   1  clock, rising edge
// - rst_n          in   1  asynchronous active-low reset
// - opcode         in   6  instr[31:26] from instruction register
// - funct          in   6  instr[5:0]
// - zero           in   1  ALU zero flag
// - mem_ready      in   1  memory completes access this cycle
// - iord           out  1  0=PC addresses memory, 1=ALUOut
// - mem_read       out  1  memory read request
// - mem_write      out  1  memory write request
// - ir_write       out  1  load instruction register
// - reg_dst        out  1  0=rt, 1=rd
// - mem_to_reg     out  1  0=ALUOut, 1=MDR
// - reg_write      out  1  register file write enable
// - alu_src_a      out  1  0=PC, 1=A
// - alu_src_b      out  2  00=B, 01=4, 10=signimm, 11=signimm<<2
// - alu_operation  out  2  00=add, 01=sub, 10=use funct
// - alu_control    out  3  aluDecoder output
// - pc_src         out  2  00=ALU result, 01=ALUOut, 10=jump target
// - pc_en          out  1  PC load = pc_write | (branch & zero)
// - illegal_op     out  1  one-cycle pulse on unsupported opcode
// - bus_err        out  1  one-cycle pulse on memory timeout
// - instr_done     out  1  one-cycle pulse in the last state of each instruction
// BEHAVIOUR
// - Reset: state=FETCH, wait_cnt=0; while rst_n=0 all strobes (ir_write, pc_en, mem_read, mem_write, reg_write, pulses) are 0 and muxes are 0.
// - Outputs are decoded from state (Moore), except: FETCH ir_write/pc_en, MEMRD/MEMWR advance gated by mem_ready, pc_en in BEQ uses zero.
// - FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=00, pc_src=00; when mem_ready: ir_write=1, pc_en=1, go DECODE; else stay.
// - DECODE: src_a=0, src_b=11, alu_op=00. Next by opcode: 100011/101011->MEMADR, 000000->RTYPE, 000100->BEQ, 001000->ADDIEX, 000010->JUMP.
// - DECODE, other opcode: illegal_op=1, next FETCH, no writes.
// - MEMADR: src_a=1, src_b=10, alu_op=00; lw->MEMRD, sw->MEMWR.
// - MEMRD: mem_read=1, iord=1; on mem_ready go MEMWB.
// - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; go FETCH.
// - MEMWR: mem_write=1, iord=1 (held until mem_ready); on mem_ready: instr_done=1, go FETCH.
// - RTYPE: src_a=1, src_b=00, alu_op=10; go ALUWB.
// - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; go FETCH.
// - BEQ: src_a=1, src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1; go FETCH.
// - ADDIEX: src_a=1, src_b=10, alu_op=00; go ADDIWB.
// - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; go FETCH.
// - JUMP: pc_src=10, pc_en=1, instr_done=1; go FETCH.
// - Wait counter (FETCH, MEMRD, MEMWR): cleared on state entry and on mem_ready; increments each non-ready cycle.
// - Timeout: when MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT with mem_ready=0: bus_err=1, no ir_write/pc_en/reg_write, next FETCH.
// - Simultaneous timeout and mem_ready: mem_ready wins, no bus_err.
// - Reset asserted mid-instruction: immediate return to FETCH; no partial writeback completes.
// - Illegal encodings of state: recover to FETCH next cycle.
// STRUCTURE
// - Shared package mips_ctrl_pkg: state_t enum, opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), alu_operation and alu_src_b/pc_src encodings.
// - Sub-module: one aluDecoder instance (funct, alu_operation -> alu_control); FSM next-state/output logic stays in this module.
// TESTING
// - Reset mid-MEMRD of lw -> state FETCH next edge, reg_write never asserts, all strobes 0 during reset.
// - add (op 0, funct 100000), mem_ready=1 -> FETCH,DECODE,RTYPE,ALUWB; alu_control=010 in RTYPE; reg_write & reg_dst=1 in cycle 4; instr_done in cycle 4.
// - lw with mem_ready low for 3 cycles in MEMRD -> stays MEMRD 4 cycles, then MEMWB with mem_to_reg=1; 5 states + 3 waits = 8 cycles total.
// - beq, zero=1 then zero=0 -> pc_en=1, pc_src=01 in BEQ; second run pc_en=0; alu_control=110.
// - opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, no reg_write/mem_write.
// - FETCH with mem_ready=0 for 16 cycles, MEM_TIMEOUT=15 -> bus_err one cycle, ir_write never 1; repeat with mem_ready=1 on the timeout cycle -> no bus_err, DECODE next.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller's alu_operation plus funct to an ALU control code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_operation,
    output logic [2:0] alu_control
);

    // Fixed add/sub for address and branch math; R-type decodes funct.
    always_comb begin
        alu_control = ALUCTL_ADD;
        case (alu_operation)
            ALU_OP_ADD: alu_control = ALUCTL_ADD;
            ALU_OP_SUB: alu_control = ALUCTL_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    6'b100000: alu_control = ALUCTL_ADD;
                    6'b100010: alu_control = ALUCTL_SUB;
                    6'b100100: alu_control = ALUCTL_AND;
                    6'b100101: alu_control = ALUCTL_OR;
                    6'b101010: alu_control = ALUCTL_SLT;
                    default:   alu_control = ALUCTL_ADD;
                endcase
            end
            default: alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath with memory stall and timeout handling.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_operation,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       bus_err,
    output logic       instr_done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_state, timed_out;

    logic       r_iord, r_mem_read, r_mem_write, r_ir_write, r_reg_dst, r_mem_to_reg;
    logic       r_reg_write, r_alu_src_a, r_pc_en, r_illegal_op, r_bus_err, r_instr_done;
    logic [1:0] r_alu_src_b, r_alu_op, r_pc_src;
    logic [2:0] r_alu_control;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // mem_ready on the timeout cycle wins over the timeout.
    assign timed_out = (MEM_TIMEOUT != 0) && mem_state && !mem_ready &&
                       (wait_cnt_q == CNT_W'(MEM_TIMEOUT));

    // Next-state and raw (ungated) output decode.
    always_comb begin
        state_d      = state_q;
        r_iord       = 1'b0;
        r_mem_read   = 1'b0;
        r_mem_write  = 1'b0;
        r_ir_write   = 1'b0;
        r_reg_dst    = 1'b0;
        r_mem_to_reg = 1'b0;
        r_reg_write  = 1'b0;
        r_alu_src_a  = 1'b0;
        r_alu_src_b  = SRCB_B;
        r_alu_op     = ALU_OP_ADD;
        r_pc_src     = PC_SRC_ALU;
        r_pc_en      = 1'b0;
        r_illegal_op = 1'b0;
        r_bus_err    = 1'b0;
        r_instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                r_mem_read  = 1'b1;
                r_alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    r_ir_write = 1'b1;
                    r_pc_en    = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                r_alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        r_illegal_op = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                r_alu_src_a = 1'b1;
                r_alu_src_b = SRCB_IMM;
                state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                r_iord     = 1'b1;
                r_mem_read = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                r_reg_write  = 1'b1;
                r_mem_to_reg = 1'b1;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                r_iord      = 1'b1;
                r_mem_write = 1'b1;
                if (mem_ready) begin
                    r_instr_done = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_RTYPE: begin
                r_alu_src_a = 1'b1;
                r_alu_op    = ALU_OP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                r_reg_write  = 1'b1;
                r_reg_dst    = 1'b1;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                r_alu_src_a  = 1'b1;
                r_alu_op     = ALU_OP_SUB;
                r_pc_src     = PC_SRC_ALUOUT;
                r_pc_en      = zero;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                r_alu_src_a = 1'b1;
                r_alu_src_b = SRCB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                r_reg_write  = 1'b1;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                r_pc_src     = PC_SRC_JUMP;
                r_pc_en      = 1'b1;
                r_instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // A timeout abandons the access; FETCH strobes are already 0 when not ready.
        if (timed_out) begin
            r_bus_err = 1'b1;
            state_d   = S_FETCH;
        end
    end

    // Wait counter restarts on every state entry, on mem_ready and after a timeout.
    always_comb begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (!mem_state || mem_ready || timed_out || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    alu_decoder u_alu_decoder (
        .funct         (funct),
        .alu_operation (r_alu_op),
        .alu_control   (r_alu_control)
    );

    // Hold every strobe and mux select at 0 while reset is asserted.
    always_comb begin
        iord          = rst_n & r_iord;
        mem_read      = rst_n & r_mem_read;
        mem_write     = rst_n & r_mem_write;
        ir_write      = rst_n & r_ir_write;
        reg_dst       = rst_n & r_reg_dst;
        mem_to_reg    = rst_n & r_mem_to_reg;
        reg_write     = rst_n & r_reg_write;
        alu_src_a     = rst_n & r_alu_src_a;
        alu_src_b     = rst_n ? r_alu_src_b : 2'b00;
        alu_operation = rst_n ? r_alu_op : 2'b00;
        alu_control   = rst_n ? r_alu_control : 3'b000;
        pc_src        = rst_n ? r_pc_src : 2'b00;
        pc_en         = rst_n & r_pc_en;
        illegal_op    = rst_n & r_illegal_op;
        bus_err       = rst_n & r_bus_err;
        instr_done    = rst_n & r_instr_done;
    end

endmodule
